fireball_launch_ctrl: RTL
=========================

Name: fireball_launch_ctrl

Overview:
- Upstream control stage for the fireball sprite address generator.
- Tracks the player's vertical position from up/down keys, once per frame.
- Manages the energy and cooldown budget.
- Issues the single-cycle gogacu launch pulse and a frozen position_y that the address generator consumes while the fireball is on screen.
- Sits between the keyboard/debounce logic and the fireball address generator. Consumes that generator's gogacu_signal as a busy indication.

Parameters:
- Y_MIN, 56, lowest legal player/fireball centre line (half sprite height 56).
- Y_MAX, 423, highest legal centre line (479-56).
- Y_RESET, 240, player centre after reset.
- STEP, 4, pixels moved per frame tick.
- ENERGY_MAX, 200, energy saturation value.
- FIRE_COST, 100, energy consumed per launch.
- COOLDOWN_FRAMES, 30, frame ticks in COOLDOWN after a fireball ends.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- key_up  in  1  debounced level, move up (decreasing y)
- key_down  in  1  debounced level, move down
- key_fire  in  1  debounced level, fire request
- fire_busy  in  1  gogacu_signal from fireball address generator
- gogacu  out  1  one-cycle launch pulse
- position_y  out  10  fireball centre line, held constant from launch until the fireball ends
- player_y  out  10  live player centre line
- energy  out  8  current energy, 0..ENERGY_MAX
- ready  out  1  high when a fire press would be accepted this cycle

Behaviour:
- Reset values:
  - player_y = position_y = Y_RESET
  - energy = 0, gogacu = 0, ready = 0
  - state IDLE, cooldown counter 0, fire edge register 0
  - Reset mid-flight aborts everything immediately.
- Fire edge: fire_rise = key_fire & ~key_fire_q. Holding the key never retriggers.
- Movement applies only on frame_tick, in every state:
  - key_up & ~key_down: player_y = max(player_y - STEP, Y_MIN).
  - key_down & ~key_up: player_y = min(player_y + STEP, Y_MAX).
  - Both or neither: player_y holds.
  - Compute in 11 bits so there is no underflow wrap.
- Energy changes only on frame_tick:
  - +1, saturating at ENERGY_MAX, when state is IDLE or COOLDOWN.
  - Held in LAUNCH/FLIGHT.
  - The FIRE_COST deduction happens on the accept cycle. If frame_tick coincides with the accept cycle, deduction wins and there is no increment that cycle.
- States:
  - IDLE: ready = (energy >= FIRE_COST) & ~fire_busy. On fire_rise & ready:
    - gogacu = 1 for that cycle (registered output, asserted the cycle after the accept condition is sampled)
    - position_y <= player_y
    - energy -= FIRE_COST
    - -> LAUNCH
  - LAUNCH: wait for fire_busy = 1 -> FLIGHT. A 4-cycle timeout with no busy -> COOLDOWN (downstream missed the pulse; the energy is not refunded).
  - FLIGHT: position_y frozen. fire_busy = 0 -> COOLDOWN, and load the cooldown counter with COOLDOWN_FRAMES.
  - COOLDOWN: decrement the counter on each frame_tick. On reaching 0 -> IDLE, and position_y <= player_y.
  - ready = 0 in every state except IDLE.
- position_y updates:
  - Tracks player_y while in IDLE; it is updated on the same cycle as player_y.
  - Frozen from the accept cycle until COOLDOWN exits.
- Fire presses outside IDLE are dropped, not queued.
- gogacu is never high for two consecutive cycles.
- A launch is never issued while fire_busy = 1.

Decomposition:
- Shared package holds:
  - the screen constants (H_ACTIVE 640, V_ACTIVE 480, FIREBALL_HALF_H 56)
  - the state encoding (IDLE/LAUNCH/FLIGHT/COOLDOWN, 2 bits)
- Derive Y_MIN and Y_MAX from the package constants.
- One natural sub-module: player_y_tracker. It holds the frame-tick clamped up/down position register, which is reusable for the player sprite address generator.

Test Plan:
- Reset then 100 frame_ticks -> energy = 100, ready = 1. One more tick -> 101. After 200 ticks energy stays at 200.
- player_y = 60, key_up held 3 frame_ticks -> 56, 56, 56. With Y_RESET = 240, key_down held 50 frame_ticks -> saturates at 423, never wraps.
- Energy 100, fire_rise, fire_busy rises next cycle, held 200 cycles:
  - gogacu high exactly 1 cycle.
  - energy = 0.
  - position_y = player_y at press and stays constant while key_up moves player_y from 240 to 200.
  - After busy falls, 30 frame_ticks, then IDLE with position_y = 200.
- key_fire held high for 1000 cycles with energy 200 -> exactly one gogacu pulse. A second press during FLIGHT or COOLDOWN -> none.
- fire_rise with energy 99 -> no gogacu. fire_rise while fire_busy = 1 in IDLE -> no gogacu.
- gogacu issued, fire_busy never rises -> COOLDOWN 4 cycles later, energy not refunded. Also: assert rst during FLIGHT -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/fireball_launch_ctrl_pkg.sv
// Shared screen geometry and launch-controller state encoding for the fireball path.
package fireball_launch_ctrl_pkg;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int FIREBALL_HALF_H = 56;

    // Cycles LAUNCH waits for the address generator to report busy.
    localparam int LAUNCH_TIMEOUT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_FLIGHT   = 2'd2,
        ST_COOLDOWN = 2'd3
    } launch_state_t;

endpackage

// File: rtl/fireball_launch_ctrl_player_y_tracker.sv
// Frame-tick driven vertical position register, clamped to the legal sprite centre range.
module player_y_tracker
    import fireball_launch_ctrl_pkg::*;
#(
    parameter int Y_MIN   = FIREBALL_HALF_H,
    parameter int Y_MAX   = V_ACTIVE - 1 - FIREBALL_HALF_H,
    parameter int Y_RESET = 240,
    parameter int STEP    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_tick,
    input  logic       i_key_up,
    input  logic       i_key_down,
    output logic [9:0] o_y,
    output logic [9:0] o_y_next
);

    localparam logic [10:0] C_STEP_W  = 11'(STEP);
    localparam logic [10:0] C_Y_MIN_W = 11'(Y_MIN);
    localparam logic [10:0] C_Y_MAX_W = 11'(Y_MAX);
    localparam logic [9:0]  C_Y_MIN   = 10'(Y_MIN);
    localparam logic [9:0]  C_Y_MAX   = 10'(Y_MAX);
    localparam logic [9:0]  C_Y_RESET = 10'(Y_RESET);

    logic [9:0]  r_y;
    logic [10:0] w_up;
    logic [10:0] w_down;

    // The extra bit exposes a borrow when stepping up past row 0.
    always_comb begin
        w_up     = {1'b0, r_y} - C_STEP_W;
        w_down   = {1'b0, r_y} + C_STEP_W;
        o_y_next = r_y;
        if (i_frame_tick && i_key_up && !i_key_down) begin
            if (w_up[10] || (w_up < C_Y_MIN_W)) begin
                o_y_next = C_Y_MIN;
            end else begin
                o_y_next = w_up[9:0];
            end
        end else if (i_frame_tick && i_key_down && !i_key_up) begin
            if (w_down > C_Y_MAX_W) begin
                o_y_next = C_Y_MAX;
            end else begin
                o_y_next = w_down[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= C_Y_RESET;
        end else begin
            r_y <= o_y_next;
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/fireball_launch_ctrl.sv
// Fireball launch controller: player position, energy/cooldown budget and the gogacu launch pulse.
module fireball_launch_ctrl
    import fireball_launch_ctrl_pkg::*;
#(
    parameter int Y_MIN           = FIREBALL_HALF_H,
    parameter int Y_MAX           = V_ACTIVE - 1 - FIREBALL_HALF_H,
    parameter int Y_RESET         = 240,
    parameter int STEP            = 4,
    parameter int ENERGY_MAX      = 200,
    parameter int FIRE_COST       = 100,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_fire,
    input  logic       fire_busy,
    output logic       gogacu,
    output logic [9:0] position_y,
    output logic [9:0] player_y,
    output logic [7:0] energy,
    output logic       ready
);

    localparam int          CD_W         = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [7:0]  C_ENERGY_MAX = 8'(ENERGY_MAX);
    localparam logic [7:0]  C_FIRE_COST  = 8'(FIRE_COST);
    localparam logic [9:0]  C_Y_RESET    = 10'(Y_RESET);
    localparam logic [CD_W-1:0] C_CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] C_CD_ONE  = CD_W'(1);
    localparam logic [1:0]  C_LAUNCH_LAST = 2'(LAUNCH_TIMEOUT - 1);

    launch_state_t   r_state;
    launch_state_t   w_state_next;
    logic            r_fire_q;
    logic            r_gogacu;
    logic            w_gogacu_next;
    logic [9:0]      r_position_y;
    logic [9:0]      w_position_y_next;
    logic [7:0]      r_energy;
    logic [7:0]      w_energy_next;
    logic [CD_W-1:0] r_cool_cnt;
    logic [CD_W-1:0] w_cool_cnt_next;
    logic [1:0]      r_launch_cnt;
    logic [1:0]      w_launch_cnt_next;
    logic [9:0]      w_player_y;
    logic [9:0]      w_player_y_next;
    logic            w_fire_rise;
    logic            w_ready;
    logic            w_accept;

    function automatic logic [7:0] energy_inc(input logic [7:0] e);
        return (e >= C_ENERGY_MAX) ? C_ENERGY_MAX : e + 8'd1;
    endfunction

    player_y_tracker #(
        .Y_MIN   (Y_MIN),
        .Y_MAX   (Y_MAX),
        .Y_RESET (Y_RESET),
        .STEP    (STEP)
    ) u_player_y (
        .clk          (clk),
        .rst          (rst),
        .i_frame_tick (frame_tick),
        .i_key_up     (key_up),
        .i_key_down   (key_down),
        .o_y          (w_player_y),
        .o_y_next     (w_player_y_next)
    );

    assign w_fire_rise = key_fire & ~r_fire_q;
    assign w_ready     = (r_state == ST_IDLE) && (r_energy >= C_FIRE_COST) && !fire_busy;
    assign w_accept    = w_fire_rise & w_ready;

    always_comb begin
        w_state_next      = r_state;
        w_gogacu_next     = 1'b0;
        w_position_y_next = r_position_y;
        w_energy_next     = r_energy;
        w_cool_cnt_next   = r_cool_cnt;
        w_launch_cnt_next = r_launch_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_position_y_next = w_player_y_next;
                if (frame_tick) begin
                    w_energy_next = energy_inc(r_energy);
                end
                // A launch snapshots the pre-move position and cancels any same-cycle regen.
                if (w_accept) begin
                    w_state_next      = ST_LAUNCH;
                    w_gogacu_next     = 1'b1;
                    w_position_y_next = w_player_y;
                    w_energy_next     = r_energy - C_FIRE_COST;
                    w_launch_cnt_next = 2'd0;
                end
            end
            ST_LAUNCH: begin
                if (fire_busy) begin
                    w_state_next = ST_FLIGHT;
                end else if (r_launch_cnt == C_LAUNCH_LAST) begin
                    w_state_next    = ST_COOLDOWN;
                    w_cool_cnt_next = C_CD_LOAD;
                end else begin
                    w_launch_cnt_next = r_launch_cnt + 2'd1;
                end
            end
            ST_FLIGHT: begin
                if (!fire_busy) begin
                    w_state_next    = ST_COOLDOWN;
                    w_cool_cnt_next = C_CD_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (frame_tick) begin
                    w_energy_next = energy_inc(r_energy);
                    if (r_cool_cnt <= C_CD_ONE) begin
                        w_state_next      = ST_IDLE;
                        w_cool_cnt_next   = '0;
                        w_position_y_next = w_player_y_next;
                    end else begin
                        w_cool_cnt_next = r_cool_cnt - C_CD_ONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fire_q     <= 1'b0;
            r_gogacu     <= 1'b0;
            r_position_y <= C_Y_RESET;
            r_energy     <= 8'd0;
            r_cool_cnt   <= '0;
            r_launch_cnt <= 2'd0;
        end else begin
            r_state      <= w_state_next;
            r_fire_q     <= key_fire;
            r_gogacu     <= w_gogacu_next;
            r_position_y <= w_position_y_next;
            r_energy     <= w_energy_next;
            r_cool_cnt   <= w_cool_cnt_next;
            r_launch_cnt <= w_launch_cnt_next;
        end
    end

    assign gogacu     = r_gogacu;
    assign position_y = r_position_y;
    assign player_y   = w_player_y;
    assign energy     = r_energy;
    assign ready      = w_ready;

endmodule
